// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// One frame per grant: latch request, stretch tx_start, await done/error or timeout, then enforce an idle gap.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int START_HOLD = 32,
    parameter int TIMEOUT    = 200000,
    parameter int GAP_CYC    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ*4-1:0] req_len,
    input  logic [NREQ*3-1:0] req_cfg,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    input  logic              rx_en,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [3:0]        length,
    output logic              parity_en,
    output logic              parity_type,
    output logic              stop,
    output logic              rx_start,
    input  logic              tx_done,
    input  logic              tx_error
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW   = $clog2(START_HOLD + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int GW   = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t            state_r;
    logic [IDXW-1:0]   rr_ptr_r;
    logic [IDXW-1:0]   idx_r;
    logic [HW-1:0]     hold_cnt_r;
    logic [TW-1:0]     wait_cnt_r;
    logic [GW-1:0]     gap_cnt_r;
    logic              tx_start_r;
    logic              busy_r;
    logic [NREQ-1:0]   ack_r;
    logic [NREQ-1:0]   err_r;
    logic [7:0]        tx_data_r;
    logic [3:0]        length_r;
    logic [2:0]        cfg_r;
    logic              rx_start_r;
    logic              done_meta_r;
    logic              done_sync_r;
    logic              done_prev_r;
    logic              error_meta_r;
    logic              error_sync_r;

    logic              win_found_s;
    logic [IDXW-1:0]   win_idx_s;
    logic [IDXW-1:0]   cand_s;
    logic [IDXW-1:0]   next_ptr_s;
    logic [7:0]        sel_data_s;
    logic [3:0]        sel_len_s;
    logic [2:0]        sel_cfg_s;
    logic              done_rise_s;

    // Round-robin winner search from rr_ptr_r upward with wrap, plus winner's request fields.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        sel_data_s  = 8'd0;
        sel_len_s   = 4'd0;
        sel_cfg_s   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDXW'((int'(rr_ptr_r) + k) % NREQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == IDXW'(i)) begin
                sel_data_s = req_data[8*i +: 8];
                sel_len_s  = req_len[4*i +: 4];
                sel_cfg_s  = req_cfg[3*i +: 3];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (win_idx_s == IDXW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_idx_s + IDXW'(1);
        end
        done_rise_s = done_sync_r & ~done_prev_r;
    end

    // Two-flop synchronizers for the UART status lines and the rx_start copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_meta_r  <= 1'b0;
            done_sync_r  <= 1'b0;
            done_prev_r  <= 1'b0;
            error_meta_r <= 1'b0;
            error_sync_r <= 1'b0;
            rx_start_r   <= 1'b0;
        end else begin
            done_meta_r  <= tx_done;
            done_sync_r  <= done_meta_r;
            done_prev_r  <= done_sync_r;
            error_meta_r <= tx_error;
            error_sync_r <= error_meta_r;
            rx_start_r   <= rx_en;
        end
    end

    // Grant/transfer FSM; done_prev_r tracks level so a tx_done already high entering WAIT is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            idx_r      <= '0;
            hold_cnt_r <= '0;
            wait_cnt_r <= '0;
            gap_cnt_r  <= '0;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            ack_r      <= '0;
            err_r      <= '0;
            tx_data_r  <= 8'd0;
            length_r   <= 4'd0;
            cfg_r      <= 3'd0;
        end else begin
            ack_r <= '0;
            err_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        idx_r      <= win_idx_s;
                        rr_ptr_r   <= next_ptr_s;
                        tx_data_r  <= sel_data_s;
                        length_r   <= sel_len_s;
                        cfg_r      <= sel_cfg_s;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (hold_cnt_r == HW'(START_HOLD - 1)) begin
                        tx_start_r <= 1'b0;
                        wait_cnt_r <= '0;
                        state_r    <= ST_WAIT;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (done_rise_s) begin
                        if (error_sync_r) begin
                            err_r[idx_r] <= 1'b1;
                        end else begin
                            ack_r[idx_r] <= 1'b1;
                        end
                        gap_cnt_r <= '0;
                        state_r   <= ST_GAP;
                    end else if (wait_cnt_r == TW'(TIMEOUT - 1)) begin
                        err_r[idx_r] <= 1'b1;
                        gap_cnt_r    <= '0;
                        state_r      <= ST_GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                ST_GAP: begin
                    if ((gap_cnt_r >= GW'(GAP_CYC - 1)) && !done_sync_r) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (gap_cnt_r < GW'(GAP_CYC - 1)) begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end else begin
                        gap_cnt_r <= gap_cnt_r;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_r;
    assign err         = err_r;
    assign busy        = busy_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign length      = length_r;
    assign parity_en   = cfg_r[2];
    assign parity_type = cfg_r[1];
    assign stop        = cfg_r[0];
    assign rx_start    = rx_start_r;

endmodule
